// File: rtl/blink_pkg.sv
// blink_pkg: shared types and constants for the LED blink sequencer.
`default_nettype none

package blink_pkg;

  localparam int DEFAULT_PRESC_DIV = 480000;
  localparam int BLINK_DUR_W       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } blink_state_e;

  // FIFO entry; the module DUR_W must not exceed BLINK_DUR_W.
  typedef struct packed {
    logic [2:0]             rgb;
    logic [BLINK_DUR_W-1:0] dur;
  } blink_cmd_t;

endpackage

`default_nettype wire

// File: rtl/blink_prescaler.sv
// blink_prescaler: free-running divider emitting one tick every PRESC_DIV cycles.
`default_nettype none

module blink_prescaler #(
  parameter int PRESC_DIV = 480000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESC_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/blink_sequencer.sv
// blink_sequencer: queued {colour, duration} steps played on a registered RGB output.
`default_nettype none

module blink_sequencer
  import blink_pkg::*;
#(
  parameter int PRESC_DIV = DEFAULT_PRESC_DIV,
  parameter int DEPTH     = 8,
  parameter int DUR_W     = BLINK_DUR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_rgb_i,
  input  logic [DUR_W-1:0] cmd_dur_i,
  input  logic             abort_i,
  output logic [2:0]       rgb_o,
  output logic             busy_o,
  output logic             step_done_o
);

  localparam int AW = $clog2(DEPTH);

  blink_state_e   state_q, state_d;
  logic [2:0]     rgb_q, rgb_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic           step_done_q, step_done_d;

  blink_cmd_t     mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q, count_d;

  logic           w_full, w_empty, w_push, w_pop, w_tick;
  blink_cmd_t     w_entry, w_head;

  assign w_full      = (count_q == (AW+1)'(DEPTH));
  assign w_empty     = (count_q == '0);
  assign cmd_ready_o = !w_full && !abort_i;
  assign w_push      = cmd_valid_i && cmd_ready_o;
  assign w_head      = mem_q[rd_ptr_q];

  assign w_entry.rgb = cmd_rgb_i;
  assign w_entry.dur = BLINK_DUR_W'(cmd_dur_i);

  blink_prescaler #(
    .PRESC_DIV(PRESC_DIV)
  ) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i((state_q != PLAY) || abort_i),
    .tick_o (w_tick)
  );

  always_comb begin
    count_d = count_q;
    if (abort_i) begin
      count_d = '0;
    end else if (w_push && !w_pop) begin
      count_d = count_q + 1'b1;
    end else if (!w_push && w_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (abort_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= w_entry;
    end
  end

  always_comb begin
    state_d     = state_q;
    rgb_d       = rgb_q;
    rem_d       = rem_q;
    step_done_d = 1'b0;
    w_pop       = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
      rgb_d   = 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          rgb_d = 3'b000;
          if (!w_empty) state_d = LOAD;
        end
        LOAD: begin
          w_pop   = 1'b1;
          rgb_d   = w_head.rgb;
          rem_d   = (w_head.dur == '0) ? DUR_W'(1) : DUR_W'(w_head.dur);
          state_d = PLAY;
        end
        PLAY: begin
          if (w_tick) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == DUR_W'(1)) begin
              step_done_d = 1'b1;
              // rgb keeps the old colour through LOAD so the hand-over has no gap.
              if (!w_empty) begin
                state_d = LOAD;
              end else begin
                state_d = IDLE;
                rgb_d   = 3'b000;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rgb_q       <= 3'b000;
      rem_q       <= '0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rgb_q       <= rgb_d;
      rem_q       <= rem_d;
      step_done_q <= step_done_d;
    end
  end

  assign rgb_o       = rgb_q;
  assign busy_o      = (state_q != IDLE);
  assign step_done_o = step_done_q;

endmodule

`default_nettype wire

// File: tb/tb_blink_sequencer.sv
// tb_blink_sequencer: directed self-checking bench, PRESC_DIV=4, DEPTH=4, DUR_W=8.
`default_nettype none

module tb_blink_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] cmd_rgb = 3'b000;
  logic [7:0] cmd_dur = 8'd0;
  logic       cmd_ready;
  logic       busy;
  logic       step_done;
  logic [2:0] rgb;

  int checks = 0;
  int errors = 0;
  int ccount [8];
  int dones;
  int busy_cycles;
  int acc;
  logic seen;

  always #5 clk = ~clk;

  blink_sequencer #(
    .PRESC_DIV(4),
    .DEPTH    (4),
    .DUR_W    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_rgb_i  (cmd_rgb),
    .cmd_dur_i  (cmd_dur),
    .abort_i    (abort),
    .rgb_o      (rgb),
    .busy_o     (busy),
    .step_done_o(step_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_obs();
    for (int i = 0; i < 8; i++) ccount[i] = 0;
    dones = 0;
    busy_cycles = 0;
  endtask

  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      ccount[rgb] = ccount[rgb] + 1;
      dones = dones + int'(step_done);
      busy_cycles = busy_cycles + int'(busy);
    end
  endtask

  task automatic push1(input logic [2:0] c, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_rgb   = c;
    cmd_dur   = d;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    // Reset with random command inputs
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'($urandom);
      cmd_rgb   = 3'($urandom);
      cmd_dur   = 8'($urandom);
      step();
    end
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(step_done), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    clr_obs();
    observe(3);
    chk("rst_idle", 32'(busy_cycles), 32'd0);

    // Single step rgb=101 dur=3
    push1(3'b101, 8'd3);
    chk("single_e0_busy", 32'(busy), 32'd0);
    step();
    chk("single_e1_busy", 32'(busy), 32'd1);
    chk("single_e1_rgb", 32'(rgb), 32'd0);
    step();
    chk("single_e2_rgb", 32'(rgb), 32'b101);
    repeat (11) step();
    chk("single_e13_rgb", 32'(rgb), 32'b101);
    chk("single_e13_done", 32'(step_done), 32'd0);
    step();
    chk("single_e14_rgb", 32'(rgb), 32'd0);
    chk("single_e14_busy", 32'(busy), 32'd0);
    chk("single_e14_done", 32'(step_done), 32'd1);
    step();
    chk("single_e15_done", 32'(step_done), 32'd0);

    // Back-to-back {110,1} then {011,2}
    cmd_valid = 1'b1;
    cmd_rgb = 3'b110; cmd_dur = 8'd1;
    step();
    cmd_rgb = 3'b011; cmd_dur = 8'd2;
    step();
    cmd_valid = 1'b0;
    clr_obs();
    observe(25);
    chk("b2b_110_cycles", 32'(ccount[6]), 32'd5);
    chk("b2b_011_cycles", 32'(ccount[3]), 32'd8);
    chk("b2b_done_pulses", 32'(dones), 32'd2);
    chk("b2b_end_busy", 32'(busy), 32'd0);

    // Zero duration behaves as one tick
    push1(3'b111, 8'd0);
    clr_obs();
    observe(15);
    chk("dur0_cycles", 32'(ccount[7]), 32'd4);
    chk("dur0_done", 32'(dones), 32'd1);

    // Full FIFO with valid held
    cmd_valid = 1'b1; cmd_rgb = 3'b010; cmd_dur = 8'd255;
    acc = 0;
    seen = 1'b0;
    for (int i = 0; i < 1100 && !seen; i++) begin
      if (cmd_ready) acc++;
      step();
      if (step_done) seen = 1'b1;
    end
    chk("full_step_end_seen", 32'(seen), 32'd1);
    chk("full_accepted", 32'(acc), 32'd5);
    chk("full_ready_in_load", 32'(cmd_ready), 32'd0);
    step();
    chk("full_ready_after_pop", 32'(cmd_ready), 32'd1);
    step();
    chk("full_ready_refilled", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    chk("full_next_rgb", 32'(rgb), 32'b010);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Abort mid-PLAY with 3 queued entries and valid high
    cmd_valid = 1'b1; cmd_rgb = 3'b001; cmd_dur = 8'd255;
    repeat (4) step();
    cmd_valid = 1'b0;
    step();
    chk("abort_pre_busy", 32'(busy), 32'd1);
    chk("abort_pre_rgb", 32'(rgb), 32'b001);
    cmd_valid = 1'b1;
    abort = 1'b1;
    #1;
    chk("abort_ready_low", 32'(cmd_ready), 32'd0);
    step();
    chk("abort_rgb", 32'(rgb), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(step_done), 32'd0);
    abort = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("abort_ready_back", 32'(cmd_ready), 32'd1);
    clr_obs();
    observe(6);
    chk("abort_fifo_empty", 32'(busy_cycles), 32'd0);
    chk("abort_no_done", 32'(dones), 32'd0);

    // Asynchronous reset mid-PLAY with a queued entry
    cmd_valid = 1'b1;
    cmd_rgb = 3'b100; cmd_dur = 8'd5;
    step();
    cmd_rgb = 3'b001;
    step();
    cmd_valid = 1'b0;
    repeat (4) step();
    chk("areset_pre_rgb", 32'(rgb), 32'b100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_rgb", 32'(rgb), 32'd0);
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_done", 32'(step_done), 32'd0);
    chk("areset_ready", 32'(cmd_ready), 32'd1);
    step();
    rst_n = 1'b1;
    clr_obs();
    observe(6);
    chk("areset_fifo_empty", 32'(busy_cycles), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
